image_ram_writer: RTL

Writable 64x64 image buffer with a byte-stream load port and a read port.
- The load side accepts a stream of bytes through a valid/ready handshake, packs each byte pair into one 12-bit RGB pixel, and writes pixels to sequential addresses 0..4095.
- The read side has the same behaviour as the background image ROM: registered address-to-rgb, one cycle of latency. Drawing logic can therefore read it in place of the ROM.
- It sits between the byte receiver (UART or link) and the rectangle/image draw stage. This lets a new background be loaded at run time.

---
 rtl/image_ram_writer.sv | 99 +++++++++
 1 files changed

// File: rtl/image_ram_writer.sv
// 64x64 RGB444 image buffer: loads byte pairs from a stream into sequential pixels,
// and offers a registered 1-cycle read port that can stand in for the background ROM.
module image_ram_writer #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096,
    parameter int RGB_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    input  logic [ADDR_W-1:0] rd_address,
    output logic [RGB_W-1:0]  rd_rgb
);

    typedef enum logic [1:0] {IDLE, LOAD_HI, LOAD_LO, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        hi;
    logic [RGB_W-1:0]  mem [DEPTH];

    logic             xfer;
    logic             wr_en;
    logic [RGB_W-1:0] wr_data;

    assign xfer    = byte_valid && byte_ready;
    assign wr_en   = (state == LOAD_LO) && xfer;
    assign wr_data = {hi, byte_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_count   <= '0;
            wr_addr    <= '0;
            hi         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= LOAD_HI;
                        byte_ready <= 1'b1;
                        busy       <= 1'b1;
                        wr_addr    <= '0;
                        wr_count   <= '0;
                    end
                end
                LOAD_HI: begin
                    if (xfer) begin
                        hi    <= byte_data[3:0];
                        state <= LOAD_LO;
                    end
                end
                LOAD_LO: begin
                    if (xfer) begin
                        wr_count <= wr_count + 1'b1;
                        if (wr_addr == LAST_ADDR) begin
                            state      <= DONE;
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            wr_addr <= wr_addr + 1'b1;
                            state   <= LOAD_HI;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM has no reset so the contents survive a reset mid-load.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Nonblocking read of the same array gives read-first behaviour on a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_rgb <= '0;
        else        rd_rgb <= mem[rd_address];
    end

endmodule
